mac_acc_requant: RTL and testbench

//   Consumer of the Q6.26 full-precision products from the MAC array multipliers.

---
 rtl/mac_acc_requant.sv | 101 ++++++++++
 tb/tb_mac_acc_requant.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_requant.sv
// Group accumulator for Q6.26 MAC products: saturating wide accumulate, then
// round-half-up requantisation to Q4.12 with optional ReLU and output saturation.
module mac_acc_requant #(
    parameter int ACC_W = 40,
    parameter bit RELU  = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [31:0] i_prod,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic signed [15:0] o_act,
    output logic               o_sat
);

    // Width of the requantised value before clamping to 16 bits.
    localparam int RW = ACC_W - 13;

    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   RND_HALF = {{(ACC_W-13){1'b0}}, 1'b1, 13'b0};

    logic signed [ACC_W-1:0] acc;
    logic                    first;
    logic                    acc_sat;

    logic                    acc_beat;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W:0]   wide;
    logic                    add_ovf;
    logic signed [ACC_W-1:0] sum;
    logic                    grp_sat;
    logic signed [ACC_W:0]   rnd;
    logic signed [RW-1:0]    r;
    logic signed [RW-1:0]    r_clip;
    logic                    req_ovf;
    logic [15:0]             act_next;
    logic                    unused_frac;

    assign o_ready  = ~o_valid | i_ready;
    assign acc_beat = i_valid & o_ready;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        base    = first ? '0 : acc;
        wide    = {base[ACC_W-1], base} + {{(ACC_W-31){i_prod[31]}}, i_prod};
        add_ovf = wide[ACC_W] ^ wide[ACC_W-1];
        sum     = wide[ACC_W-1:0];
        if (add_ovf) begin
            sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        // Saturation is sticky across the group so the output reports it.
        grp_sat = (~first & acc_sat) | add_ovf;

        rnd         = {sum[ACC_W-1], sum} + RND_HALF;
        r           = rnd[ACC_W:14];
        unused_frac = ^rnd[13:0];
        r_clip      = (RELU && r[RW-1]) ? '0 : r;

        // Fits in 16 bits only if every bit above bit 15 copies bit 15.
        req_ovf  = (r_clip[RW-1:16] != {(RW-16){r_clip[15]}});
        act_next = r_clip[15:0];
        if (req_ovf) begin
            act_next = r_clip[RW-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc     <= '0;
            first   <= 1'b1;
            acc_sat <= 1'b0;
            o_valid <= 1'b0;
            o_act   <= '0;
            o_sat   <= 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (acc_beat) begin
                if (i_last) begin
                    o_act   <= act_next;
                    o_sat   <= req_ovf | grp_sat;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    first   <= 1'b1;
                    acc_sat <= 1'b0;
                end else begin
                    acc     <= sum;
                    first   <= 1'b0;
                    acc_sat <= grp_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_acc_requant.sv
// Scoreboard bench for mac_acc_requant: three variants (default, ReLU, 33-bit accumulator)
// share one stimulus stream; a reference model fills per-variant expectation queues.
module tb_mac_acc_requant;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_last;
    logic        i_ready;
    logic [31:0] i_prod;

    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  sat;
    logic [15:0] act [3];

    int n_vec = 0;
    int n_bad = 0;

    longint      m_acc   [3];
    bit          m_first [3];
    bit          m_gsat  [3];
    logic [16:0] q0 [$];
    logic [16:0] q1 [$];
    logic [16:0] q2 [$];

    always #5 i_clk = ~i_clk;

    mac_acc_requant #(.ACC_W(40), .RELU(1'b0)) u_base (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy[0]),
        .i_prod(i_prod), .i_last(i_last), .o_valid(vld[0]), .i_ready(i_ready),
        .o_act(act[0]), .o_sat(sat[0])
    );

    mac_acc_requant #(.ACC_W(40), .RELU(1'b1)) u_relu (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy[1]),
        .i_prod(i_prod), .i_last(i_last), .o_valid(vld[1]), .i_ready(i_ready),
        .o_act(act[1]), .o_sat(sat[1])
    );

    mac_acc_requant #(.ACC_W(33), .RELU(1'b0)) u_narrow (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy[2]),
        .i_prod(i_prod), .i_last(i_last), .o_valid(vld[2]), .i_ready(i_ready),
        .o_act(act[2]), .o_sat(sat[2])
    );

    function automatic int width_of(int k);
        return (k == 2) ? 33 : 40;
    endfunction

    function automatic void push_exp(int k, logic [16:0] v);
        case (k)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int pending();
        return q0.size() + q1.size() + q2.size();
    endfunction

    task automatic pop_exp(input int k, output bit empty, output logic [16:0] v);
        empty = 1'b0;
        v     = '0;
        case (k)
            0:       if (q0.size() == 0) empty = 1'b1; else v = q0.pop_front();
            1:       if (q1.size() == 0) empty = 1'b1; else v = q1.pop_front();
            default: if (q2.size() == 0) empty = 1'b1; else v = q2.pop_front();
        endcase
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 0;
            m_first[k] = 1'b1;
            m_gsat[k]  = 1'b0;
        end
    endfunction

    // Reference behaviour of one accepted beat for variant k.
    function automatic void model_beat(int k, logic [31:0] p, bit last);
        longint mx   = (longint'(1) <<< (width_of(k) - 1)) - 1;
        longint mn   = -mx - 1;
        longint s    = (m_first[k] ? 0 : m_acc[k]) + longint'($signed(p));
        bit     gs   = m_first[k] ? 1'b0 : m_gsat[k];
        longint r;
        logic [15:0] a;
        bit     os;
        if (s > mx) begin s = mx; gs = 1'b1; end
        if (s < mn) begin s = mn; gs = 1'b1; end
        if (last) begin
            r  = (s + 8192) >>> 14;
            if (k == 1 && r < 0) r = 0;
            os = gs;
            if (r > 32767) begin
                a = 16'h7FFF; os = 1'b1;
            end else if (r < -32768) begin
                a = 16'h8000; os = 1'b1;
            end else begin
                a = r[15:0];
            end
            push_exp(k, {a, os});
            m_acc[k]   = 0;
            m_first[k] = 1'b1;
            m_gsat[k]  = 1'b0;
        end else begin
            m_acc[k]   = s;
            m_first[k] = 1'b0;
            m_gsat[k]  = gs;
        end
    endfunction

    // Pops and compares every output transfer (o_valid & i_ready at the next edge).
    task automatic monitor();
        bit          empty;
        logic [16:0] e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && i_ready) begin
                for (int k = 0; k < 3; k++) begin
                    if (vld[k]) begin
                        pop_exp(k, empty, e);
                        n_vec++;
                        if (empty) begin
                            n_bad++;
                            $display("FAIL out%0d_unexpected: got act=%h sat=%b, no result expected", k, act[k], sat[k]);
                        end else if ({act[k], sat[k]} !== e) begin
                            n_bad++;
                            $display("FAIL out%0d_value: got act=%h sat=%b, expected act=%h sat=%b", k, act[k], sat[k], e[16:1], e[0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive_beat(input logic [31:0] p, input bit last, input int gap);
        bit ok = 1'b0;
        repeat (gap) begin @(posedge i_clk); #1; end
        i_valid = 1'b1;
        i_prod  = p;
        i_last  = last;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge i_clk);
            if (rdy[0]) begin
                for (int k = 0; k < 3; k++) model_beat(k, p, last);
                ok = 1'b1;
            end
            @(posedge i_clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: beat %h not accepted within 200 cycles", p);
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && pending() != 0; c++) begin
            @(posedge i_clk);
            #1;
        end
        n_vec++;
        if (pending() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results still outstanding, expected 0", pending());
        end
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_prod  = '0;
        i_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_vec++;
        if ({vld[0], act[0], sat[0], rdy[0]} !== {1'b0, 16'h0000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b act=%h sat=%b ready=%b, expected 0 0000 0 1", vld[0], act[0], sat[0], rdy[0]);
        end
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_basic();
        drive_beat(32'h0400_0000, 1'b0, 0);
        n_vec++;
        if (vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_midgroup_valid: got %b, expected 0", vld[0]);
        end
        drive_beat(32'h0200_0000, 1'b1, 0);
        n_vec++;
        if ({vld[0], act[0], sat[0]} !== {1'b1, 16'h1800, 1'b0}) begin
            n_bad++;
            $display("FAIL basic_latency: got valid=%b act=%h sat=%b, expected 1 1800 0", vld[0], act[0], sat[0]);
        end
        wait_drain();
    endtask

    task automatic test_rounding();
        drive_beat(32'h0000_2000, 1'b1, 1);
        n_vec++;
        if (act[0] !== 16'h0001) begin
            n_bad++;
            $display("FAIL round_half_up_pos: got %h, expected 0001", act[0]);
        end
        drive_beat(32'hFFFF_E000, 1'b1, 1);
        n_vec++;
        if (act[0] !== 16'h0000) begin
            n_bad++;
            $display("FAIL round_half_up_neg: got %h, expected 0000", act[0]);
        end
        wait_drain();
    endtask

    task automatic test_requant_sat();
        for (int i = 0; i < 8; i++) drive_beat(32'h7FFF_FFFF, i == 7, 0);
        n_vec++;
        if ({act[0], sat[0]} !== {16'h7FFF, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_positive: got act=%h sat=%b, expected 7fff 1", act[0], sat[0]);
        end
        for (int i = 0; i < 8; i++) drive_beat(32'h8000_0000, i == 7, 0);
        n_vec++;
        if ({act[0], sat[0]} !== {16'h8000, 1'b1}) begin
            n_bad++;
            $display("FAIL sat_negative: got act=%h sat=%b, expected 8000 1", act[0], sat[0]);
        end
        wait_drain();
    endtask

    task automatic test_relu();
        drive_beat(32'hFC00_0000, 1'b1, 0);
        n_vec++;
        if ({act[0], sat[0]} !== {16'hF000, 1'b0}) begin
            n_bad++;
            $display("FAIL relu_off: got act=%h sat=%b, expected f000 0", act[0], sat[0]);
        end
        n_vec++;
        if ({act[1], sat[1]} !== {16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL relu_on: got act=%h sat=%b, expected 0000 0", act[1], sat[1]);
        end
        wait_drain();
    endtask

    // Narrow accumulator clips on the way up, so the group ends near zero but flagged.
    task automatic test_acc_sat();
        for (int i = 0; i < 3; i++) drive_beat(32'h7FFF_FFFF, 1'b0, 0);
        drive_beat(32'h8000_0000, 1'b0, 0);
        drive_beat(32'h8000_0000, 1'b1, 0);
        n_vec++;
        if ({act[2], sat[2]} !== {16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL acc_sat_sticky: got act=%h sat=%b, expected 0000 1", act[2], sat[2]);
        end
        wait_drain();
    endtask

    task automatic test_hold();
        i_ready = 1'b0;
        drive_beat(32'h0400_0000, 1'b0, 0);
        drive_beat(32'h0200_0000, 1'b1, 0);
        fork
            drive_beat(32'h0100_0000, 1'b1, 0);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge i_clk);
                    n_vec++;
                    if ({rdy[0], vld[0], act[0]} !== {1'b0, 1'b1, 16'h1800}) begin
                        n_bad++;
                        $display("FAIL hold_stall: got ready=%b valid=%b act=%h, expected 0 1 1800", rdy[0], vld[0], act[0]);
                    end
                end
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        n_vec++;
        if ({vld[0], act[0]} !== {1'b1, 16'h0400}) begin
            n_bad++;
            $display("FAIL hold_second: got valid=%b act=%h, expected 1 0400", vld[0], act[0]);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            p = 32'h0010_0000 * (i + 1);
            drive_beat(p, 1'b1, 0);
            n_vec++;
            if (vld[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_valid_%0d: got %b, expected 1", i, vld[0]);
            end
        end
        wait_drain();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int g = 0; g < 24; g++) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) begin
                        logic [31:0] p = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() >>> 4);
                        drive_beat(p, b == len - 1, $urandom_range(0, 2));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge i_clk);
                    #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_midgroup();
        for (int i = 0; i < 3; i++) drive_beat(32'h7FFF_FFFF, 1'b0, 0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        n_vec++;
        if (vld[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_valid: got %b, expected 0", vld[0]);
        end
        drive_beat(32'h0100_0000, 1'b1, 0);
        n_vec++;
        if ({act[0], sat[0]} !== {16'h0400, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_discard: got act=%h sat=%b, expected 0400 0", act[0], sat[0]);
        end
        wait_drain();
    endtask

    initial begin
        fork
            monitor();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        test_basic();
        test_rounding();
        test_requant_sat();
        test_relu();
        test_acc_sat();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_midgroup();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
